// File: rtl/uart_tx_fifo_if.sv
// Byte-queue side and sender side of the UART transmit FIFO, bundled so the
// FIFO and its environment connect through one port each.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      WR_DATA;
  logic            WR_EN;
  logic            FULL;
  logic            EMPTY;
  logic [ADDR_W:0] COUNT;
  logic            OVERFLOW;
  logic [7:0]      TX_DATA;
  logic            TX_EN;
  logic            TX_BUSY;

  // Environment view: the bus writer plus the UART sender's busy flag.
  modport master (
    output WR_DATA, WR_EN, TX_BUSY,
    input  FULL, EMPTY, COUNT, OVERFLOW, TX_DATA, TX_EN
  );

  // FIFO view.
  modport slave (
    input  WR_DATA, WR_EN, TX_BUSY,
    output FULL, EMPTY, COUNT, OVERFLOW, TX_DATA, TX_EN
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue in front of a UART sender. Bytes are written at any
// rate into a circular buffer and issued one at a time with a single-cycle
// TX_EN strobe, waiting for the sender's busy flag to rise and fall between
// bytes. Occupancy is tracked by an explicit counter so full and empty never
// depend on pointer comparison.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           sysclk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  logic [7:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;

  logic full;
  logic empty;
  logic wr_acc;
  logic pop;

  // Flags come from the registered count, so a write in the same cycle as a
  // pop from a full queue still sees FULL and is dropped.
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.WR_EN && !full;

  assign bus.FULL     = full;
  assign bus.EMPTY    = empty;
  assign bus.COUNT    = count_q;
  assign bus.OVERFLOW = overflow_q;
  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_EN    = tx_en_q;

  // Storage array: written on accepted writes only.
  // NOTE: the array has no reset; its contents are unobservable until written,
  // and leaving it out of the reset lets it map onto plain RAM/flops without
  // a reset tree.
  always_ff @(posedge sysclk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= bus.WR_DATA;
    end
  end

  // Write side: pointer advance, occupancy arithmetic and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (bus.WR_EN && full) begin
      overflow_d = 1'b1;
    end
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Issue FSM: pop one byte when the sender is idle, strobe it for one cycle,
  // then follow the sender's busy flag up and back down.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.TX_BUSY) begin
          pop       = 1'b1;
          tx_data_d = mem[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          tx_en_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.TX_BUSY) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.TX_BUSY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset flushes the queue and drops TX_EN at once.
  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // value of every other flop, independent of statement order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit byte queue placed directly upstream of the UART sender.
- Accepts bytes from the CPU/peripheral bus side at any rate and stores them in a circular buffer.
- Issues one byte at a time to the sender using its TX_DATA/TX_EN/busy handshake, so back-to-back writes are serialised onto the line without loss while space remains.

Parameters:
- DEPTH, 16, number of byte entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- sysclk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- WR_DATA  input  8  byte to enqueue.
- WR_EN  input  1  enqueue strobe; one byte per cycle while high.
- FULL  output  1  high when COUNT==DEPTH.
- EMPTY  output  1  high when COUNT==0.
- COUNT  output  ADDR_W+1  current occupancy, 0..DEPTH.
- OVERFLOW  output  1  sticky; set when WR_EN arrives while FULL.
- TX_DATA  output  8  byte presented to the sender; registered.
- TX_EN  output  1  one-cycle start strobe to the sender; registered.
- TX_BUSY  input  1  sender busy flag (the sender's sendstatus); high from the cycle after it accepts a byte until the stop bit completes.

Behaviour:
- Reset (asynchronous, active-high): rd_ptr=0, wr_ptr=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, TX_DATA=8'h00, TX_EN=0, state=IDLE. Memory contents are don't-care.
- Reset asserted mid-transfer:
  - Queue is flushed and TX_EN drops immediately.
  - A byte already accepted by the sender is not recalled.
  - After reset releases, FSM starts in IDLE and must see TX_BUSY==0 before issuing.
- Write side:
  - If WR_EN && !FULL: mem[wr_ptr]<=WR_DATA, wr_ptr<=wr_ptr+1 (wraps DEPTH-1→0).
  - If WR_EN && FULL: byte dropped, OVERFLOW<=1. OVERFLOW clears only on reset.
- FULL, EMPTY and COUNT are derived from registered COUNT and are valid the cycle after the edge that changed it.
- COUNT arithmetic per edge: +1 for an accepted write, −1 for a pop. Simultaneous write and pop leaves COUNT unchanged.
- FULL is evaluated on pre-edge COUNT, so a write in the same cycle as a pop from a full queue is still dropped and sets OVERFLOW.
- No bypass: a byte written into an empty queue is issued no earlier than the following cycle.
- Read/issue FSM, states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if !EMPTY && !TX_BUSY: TX_DATA<=mem[rd_ptr], rd_ptr<=rd_ptr+1 (wraps), COUNT decrements (pop), TX_EN<=1, →ISSUE. Otherwise stay.
  - ISSUE: TX_EN is high for exactly this one cycle with TX_DATA stable, and the sender captures on this edge. TX_EN<=0, →WAIT_BUSY.
  - WAIT_BUSY: stay until TX_BUSY==1, then →WAIT_DONE. No timeout.
  - WAIT_DONE: stay until TX_BUSY==0, then →IDLE.
- TX_DATA holds its last value outside ISSUE.
- Latency: first write into an empty, idle queue at edge N → pop at edge N+1 → TX_EN high during cycle N+1..N+2.
- Minimum gap between TX_EN pulses is the sender's full frame time plus 2 cycles (WAIT_DONE→IDLE→ISSUE).
- Pointers are ADDR_W bits and wrap naturally. Full/empty is disambiguated by COUNT, not by pointer compare.

Test Plan:
- Reset then single write 8'hA5 with TX_BUSY model idle → TX_EN one cycle high 2 edges after write, TX_DATA==8'hA5, COUNT back to 0, EMPTY=1.
- Burst write 8'h01..8'h05 on 5 consecutive cycles against a bus-functional sender (busy for 100 cycles after accept) → exactly 5 TX_EN pulses in order 01..05, each issued only after TX_BUSY falls; COUNT peaks at 4.
- Write 17 bytes with TX_BUSY held high → COUNT==16, FULL=1, 17th byte dropped, OVERFLOW=1. Release TX_BUSY → 16 bytes drained in order, OVERFLOW stays 1.
- Drain-and-refill across wrap-around: 40 bytes with interleaved writes and pops → output sequence matches input with no duplicates or losses; wr_ptr/rd_ptr wrap past 15.
- Simultaneous pop and write while COUNT==16 → write dropped, OVERFLOW=1, COUNT==15. Simultaneous pop and write at COUNT==3 → COUNT stays 3.
- Assert reset during WAIT_DONE with 6 bytes queued → COUNT=0, TX_EN=0, state IDLE immediately. With TX_BUSY still high after release, no TX_EN until TX_BUSY falls and a new byte is written.
